// File: rtl/seg7_scan_capture.sv
// Purpose : recover per-digit BCD values from multiplexed 7-segment lines
//           (seg_in ABCDEFG active-high, one-hot dig_sel), with glitch filtering.
// Latency : pin change -> outputs updated STABLE_CYCLES+2 clocks later
//           (2-flop sync, STABLE_CYCLES-long stability run, 1 capture register).
// Backpressure: none; the panel scan is free-running and the block never stalls it.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_in       segment lines, bit6=A .. bit0=G, 1 = lit
//   dig_sel      digit enables, active-high, one-hot or zero
//   clear        synchronous clear of the seen-mask and err (digits are kept)
//   digits_out   BCD per digit, digit i at [4i+3:4i]
//   blank_out    1 = digit i was last captured as all segments off
//   frame_valid  1-cycle pulse once every digit has been captured since the last pulse
//   err          sticky: illegal segment pattern or multi-hot dig_sel was captured
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    frame_valid,
    output logic                    err
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // ------------------------------------------------------------------
    // Input synchronizer: {seg_in, dig_sel} crosses from the panel domain.
    // sync2_q is the "sample" the rest of the logic works on.
    // ------------------------------------------------------------------
    logic [SW-1:0] sync1_q;
    logic [SW-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {seg_in, dig_sel};
            sync2_q <= sync1_q;
        end
    end

    logic [6:0]            s_seg;
    logic [NUM_DIGITS-1:0] s_sel;

    assign s_seg = sync2_q[SW-1:NUM_DIGITS];
    assign s_sel = sync2_q[NUM_DIGITS-1:0];

    // ------------------------------------------------------------------
    // Stability counter. sync1_q is the sample of the next cycle, so
    // comparing it with sync2_q tells whether the sample is about to change.
    // cnt_q therefore equals the length of the current run of identical
    // samples (saturating), aligned with sync2_q.
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sample_change;
    logic          cap_q;
    logic          cap_d;

    assign sample_change = (sync1_q != sync2_q);

    always_comb begin
        cnt_d = cnt_q;
        if (sample_change) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Strobe only on the cycle the run length first reaches the target.
    // The sample_change term covers STABLE_CYCLES=1, where a new run
    // starts already saturated.
    assign cap_d = (cnt_d == CNT_MAX) && ((cnt_q != CNT_MAX) || sample_change);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            cap_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cap_q <= cap_d;
        end
    end

    // ------------------------------------------------------------------
    // Segment decode: returns {legal, blank, bcd}.
    // ------------------------------------------------------------------
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'h7E:   r = {2'b10, 4'd0};
            7'h30:   r = {2'b10, 4'd1};
            7'h6D:   r = {2'b10, 4'd2};
            7'h79:   r = {2'b10, 4'd3};
            7'h33:   r = {2'b10, 4'd4};
            7'h5B:   r = {2'b10, 4'd5};
            7'h5F:   r = {2'b10, 4'd6};
            7'h70:   r = {2'b10, 4'd7};
            7'h7F:   r = {2'b10, 4'd8};
            7'h73:   r = {2'b10, 4'd9};
            7'h00:   r = {2'b11, 4'd0};
            default: r = {2'b00, 4'd0};
        endcase
        return r;
    endfunction

    logic [5:0] dec;
    logic       dec_legal;
    logic       dec_blank;
    logic [3:0] dec_bcd;
    logic       sel_zero;
    logic       sel_onehot;

    assign dec        = decode_seg(s_seg);
    assign dec_legal  = dec[5];
    assign dec_blank  = dec[4];
    assign dec_bcd    = dec[3:0];
    assign sel_zero   = (s_sel == '0);
    assign sel_onehot = $onehot(s_sel);

    // ------------------------------------------------------------------
    // Capture / frame / clear state update.
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q,  blank_d;
    logic [NUM_DIGITS-1:0]   seen_q,   seen_d;
    logic                    frame_q,  frame_d;
    logic                    err_q,    err_d;

    always_comb begin
        digits_d = digits_q;
        blank_d  = blank_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        err_d    = err_q;

        if (clear) begin
            // clear wins over a capture in the same cycle and over a
            // pending frame pulse; digit values are deliberately kept.
            seen_d = '0;
            err_d  = 1'b0;
        end else begin
            if (seen_q == '1) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
            if (cap_q && !sel_zero) begin
                if (!sel_onehot) begin
                    err_d = 1'b1;
                end else if (!dec_legal) begin
                    err_d = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (s_sel[i]) begin
                            digits_d[4*i +: 4] = dec_bcd;
                            blank_d[i]         = dec_blank;
                            seen_d[i]          = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            blank_q  <= '1;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            blank_q  <= blank_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign digits_out  = digits_q;
    assign blank_out   = blank_q;
    assign frame_valid = frame_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        clear;
    logic [15:0] digits_out;
    logic [3:0]  blank_out;
    logic        frame_valid;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int fv_count = 0;

    seg7_scan_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .clear       (clear),
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .frame_valid (frame_valid),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) fv_count <= fv_count + 1;
    end

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  sel;
        logic [15:0] exp_dig;
        logic [3:0]  exp_blank;
        logic        exp_err;
        int          exp_frames;
    } vec_t;

    vec_t tbl [12];
    vec_t sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; holds the pattern for n edges, returns at posedge+1.
    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_digit(input logic [6:0] s, input logic [3:0] d);
        drive(s, d, 20);
        drive(7'h00, 4'h0, 4);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   frames_before;

        // seg, sel, expected digits, blank, err, cumulative frame pulses
        tbl[0]  = '{7'h30, 4'h1, 16'h0001, 4'hE, 1'b0, 0};
        tbl[1]  = '{7'h6D, 4'h2, 16'h0021, 4'hC, 1'b0, 0};
        tbl[2]  = '{7'h79, 4'h4, 16'h0321, 4'h8, 1'b0, 0};
        tbl[3]  = '{7'h33, 4'h8, 16'h4321, 4'h0, 1'b0, 1};
        tbl[4]  = '{7'h7E, 4'h1, 16'h4320, 4'h0, 1'b0, 1};
        tbl[5]  = '{7'h00, 4'h2, 16'h4300, 4'h2, 1'b0, 1};
        tbl[6]  = '{7'h5F, 4'h4, 16'h4600, 4'h2, 1'b0, 1};
        tbl[7]  = '{7'h73, 4'h8, 16'h9600, 4'h2, 1'b0, 2};
        tbl[8]  = '{7'h70, 4'h1, 16'h9607, 4'h2, 1'b0, 2};
        tbl[9]  = '{7'h7F, 4'h2, 16'h9687, 4'h0, 1'b0, 2};
        tbl[10] = '{7'h5B, 4'h4, 16'h9587, 4'h0, 1'b0, 2};
        tbl[11] = '{7'h01, 4'h2, 16'h9587, 4'h0, 1'b1, 2};

        rst_n   = 1'b0;
        seg_in  = 7'h00;
        dig_sel = 4'h0;
        clear   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset: nothing must be captured or flagged.
        drive(7'h00, 4'h0, 12);
        @(negedge clk);
        chk("reset_digits", 32'(digits_out), 32'h0000);
        chk("reset_blank",  32'(blank_out),  32'hF);
        chk("reset_frame",  32'(frame_valid), 32'h0);
        chk("reset_err",    32'(err),        32'h0);
        chk("reset_fvcnt",  32'(fv_count),   32'h0);
        @(posedge clk);
        #1;

        // Table-driven scans through the scoreboard.
        for (int k = 0; k < 12; k++) begin
            sb_q.push_back(tbl[k]);
            scan_digit(tbl[k].seg, tbl[k].sel);
            v = sb_q.pop_front();
            chk($sformatf("vec%0d_digits", k), 32'(digits_out), 32'(v.exp_dig));
            chk($sformatf("vec%0d_blank", k),  32'(blank_out),  32'(v.exp_blank));
            chk($sformatf("vec%0d_err", k),    32'(err),        32'(v.exp_err));
            chk($sformatf("vec%0d_frames", k), 32'(fv_count),   32'(v.exp_frames));
        end

        // clear drops err, keeps digits.
        pulse_clear();
        @(posedge clk);
        #1;
        chk("clear_err",    32'(err),        32'h0);
        chk("clear_digits", 32'(digits_out), 32'h9587);

        // Glitch: 7F briefly, then 5B; digit 0 must go 7 -> 5, never 8,
        // updating exactly 10 edges after 5B is applied.
        drive(7'h7F, 4'h1, 5);
        seg_in = 7'h5B;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("glitch_not8_e%0d", k), 32'(digits_out[3:0] == 4'd8), 32'h0);
            if (k == 9)  chk("glitch_before", 32'(digits_out[3:0]), 32'h7);
            if (k == 10) chk("glitch_after",  32'(digits_out[3:0]), 32'h5);
        end
        drive(7'h5B, 4'h1, 8);
        drive(7'h00, 4'h0, 4);
        chk("glitch_final", 32'(digits_out), 32'h9585);

        // Multi-hot dig_sel: err only.
        pulse_clear();
        frames_before = fv_count;
        scan_digit(7'h30, 4'b0011);
        chk("multihot_err",    32'(err),        32'h1);
        chk("multihot_digits", 32'(digits_out), 32'h9585);
        chk("multihot_blank",  32'(blank_out),  32'h0);
        chk("multihot_frames", 32'(fv_count),   32'(frames_before));
        pulse_clear();
        chk("multihot_clear",  32'(err),        32'h0);

        // Long hold must capture once: seen bit cleared mid-hold must stay clear,
        // so scanning the other three digits must not complete a frame.
        frames_before = fv_count;
        drive(7'h30, 4'h1, 100);
        pulse_clear();
        drive(7'h30, 4'h1, 99);
        drive(7'h00, 4'h0, 4);
        scan_digit(7'h6D, 4'h2);
        scan_digit(7'h79, 4'h4);
        scan_digit(7'h33, 4'h8);
        chk("hold_no_frame", 32'(fv_count),   32'(frames_before));
        chk("hold_digits",   32'(digits_out), 32'h4321);

        // Reset mid-frame: outputs return immediately, partial frame discarded.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_digits", 32'(digits_out),  32'h0000);
        chk("midrst_blank",  32'(blank_out),   32'hF);
        chk("midrst_frame",  32'(frame_valid), 32'h0);
        chk("midrst_err",    32'(err),         32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frames_before = fv_count;
        scan_digit(7'h30, 4'h1);
        chk("postrst_partial", 32'(fv_count), 32'(frames_before));
        scan_digit(7'h6D, 4'h2);
        scan_digit(7'h79, 4'h4);
        scan_digit(7'h33, 4'h8);
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_frames", 32'(fv_count),   32'(frames_before + 1));
        chk("postrst_digits", 32'(digits_out), 32'h4321);
        chk("postrst_blank",  32'(blank_out),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
